// File: rtl/mt_regfile_clr.sv
// Multithreaded integer register file: one bank per hart, two combinational read ports,
// one write port, and a sequential clear engine for power-up init and per-hart flush.
module mt_regfile_clr #(
   parameter int XLEN    = 32,
   parameter int NREGS   = 32,
   parameter int NHARTS  = 4,
   parameter int BYPASS  = 1,
   parameter int ZERO_R0 = 1,
   localparam int AW = $clog2(NREGS),
   localparam int HW = (NHARTS > 1) ? $clog2(NHARTS) : 1
) (
   input  logic              clk,
   input  logic              n_reset,
   input  logic              we,
   input  logic [HW-1:0]     wr_hart,
   input  logic [AW-1:0]     wr_addr,
   input  logic [XLEN-1:0]   wr_data,
   input  logic [HW-1:0]     rd_hart,
   input  logic [AW-1:0]     rd_addr1,
   input  logic [AW-1:0]     rd_addr2,
   output logic [XLEN-1:0]   rd_data1,
   output logic [XLEN-1:0]   rd_data2,
   input  logic              clr_req,
   input  logic [HW-1:0]     clr_hart,
   output logic [NHARTS-1:0] hart_busy,
   output logic              clr_done
);

   typedef enum logic [1:0] {INIT, IDLE, CLR} state_t;

   localparam logic [AW-1:0] LAST = AW'(NREGS - 1);
   localparam logic [HW:0]   NH   = (HW + 1)'(NHARTS);

   state_t                  state, state_nx;
   logic [AW-1:0]           cnt, cnt_nx;
   logic [HW-1:0]           tgt, tgt_nx;
   logic [NHARTS-1:0]       busy_nx;
   logic                    done_nx;
   logic                    zero_all, zero_tgt;
   logic [(1 << HW)-1:0]    busy_pad;
   logic [(1 << HW)-1:0]    clr_onehot;
   logic                    wr_qual, rd_ok, clr_ok;

   logic [XLEN-1:0] mem [NHARTS][NREGS];

   // Padding to a power of two lets any hart index address the busy vector safely.
   always_comb begin
      busy_pad = '0;
      busy_pad[NHARTS-1:0] = hart_busy;
      clr_onehot = '0;
      clr_onehot[clr_hart] = 1'b1;
   end

   assign clr_ok  = ({1'b0, clr_hart} < NH);
   assign rd_ok   = ({1'b0, rd_hart} < NH) && !busy_pad[rd_hart];
   assign wr_qual = we && ({1'b0, wr_hart} < NH) && !busy_pad[wr_hart]
                    && !((ZERO_R0 != 0) && (wr_addr == '0));

   always_ff @(posedge clk) begin
      if (!n_reset) begin
         state     <= INIT;
         cnt       <= '0;
         tgt       <= '0;
         hart_busy <= '1;
         clr_done  <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         tgt       <= tgt_nx;
         hart_busy <= busy_nx;
         clr_done  <= done_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      tgt_nx   = tgt;
      busy_nx  = hart_busy;
      done_nx  = 1'b0;
      zero_all = 1'b0;
      zero_tgt = 1'b0;
      case (state)
         INIT: begin
            zero_all = 1'b1;
            cnt_nx   = cnt + 1'b1;
            if (cnt == LAST) begin
               state_nx = IDLE;
               busy_nx  = '0;
               done_nx  = 1'b1;
            end
         end
         IDLE: begin
            if (clr_req && clr_ok) begin
               state_nx = CLR;
               tgt_nx   = clr_hart;
               cnt_nx   = '0;
               busy_nx  = hart_busy | clr_onehot[NHARTS-1:0];
            end
         end
         CLR: begin
            zero_tgt = 1'b1;
            cnt_nx   = cnt + 1'b1;
            if (cnt == LAST) begin
               state_nx = IDLE;
               busy_nx  = '0;
               done_nx  = 1'b1;
            end
         end
         default: state_nx = INIT;
      endcase
   end

   // A user write never targets a bank the engine is zeroing, since that bank is busy.
   always_ff @(posedge clk) begin
      if (wr_qual)
         mem[wr_hart][wr_addr] <= wr_data;
      for (int h = 0; h < NHARTS; h++) begin
         if (zero_all || (zero_tgt && (tgt == HW'(h))))
            mem[h][cnt] <= '0;
      end
   end

   always_comb begin
      rd_data1 = '0;
      if (rd_ok && !((ZERO_R0 != 0) && (rd_addr1 == '0))) begin
         if ((BYPASS != 0) && wr_qual && (wr_hart == rd_hart) && (wr_addr == rd_addr1))
            rd_data1 = wr_data;
         else
            rd_data1 = mem[rd_hart][rd_addr1];
      end
   end

   always_comb begin
      rd_data2 = '0;
      if (rd_ok && !((ZERO_R0 != 0) && (rd_addr2 == '0))) begin
         if ((BYPASS != 0) && wr_qual && (wr_hart == rd_hart) && (wr_addr == rd_addr2))
            rd_data2 = wr_data;
         else
            rd_data2 = mem[rd_hart][rd_addr2];
      end
   end

endmodule

// File: tb/tb_mt_regfile_clr.sv
// Scoreboard bench for mt_regfile_clr: three configurations share one stimulus stream
// and are compared each cycle against a bank-level reference model.
module tb_mt_regfile_clr;

   localparam int NC = 3;
   localparam int NR = 32;

   logic        clk = 1'b0;
   logic        n_reset = 1'b0;
   logic        we = 1'b0;
   logic [1:0]  wr_hart = '0;
   logic [4:0]  wr_addr = '0;
   logic [31:0] wr_data = '0;
   logic [1:0]  rd_hart = '0;
   logic [4:0]  rd_addr1 = '0;
   logic [4:0]  rd_addr2 = '0;
   logic        clr_req = 1'b0;
   logic [1:0]  clr_hart = '0;

   logic [31:0] d1_a, d2_a, d1_b, d2_b, d1_c, d2_c;
   logic [3:0]  busy_a, busy_c;
   logic [2:0]  busy_b;
   logic        done_a, done_b, done_c;

   int nh_c [NC] = '{4, 3, 4};
   int byp_c[NC] = '{1, 1, 0};
   int z0_c [NC] = '{1, 1, 0};

   always #5 clk = ~clk;

   mt_regfile_clr u_dut_a (
      .clk(clk), .n_reset(n_reset), .we(we), .wr_hart(wr_hart), .wr_addr(wr_addr),
      .wr_data(wr_data), .rd_hart(rd_hart), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .rd_data1(d1_a), .rd_data2(d2_a), .clr_req(clr_req), .clr_hart(clr_hart),
      .hart_busy(busy_a), .clr_done(done_a));

   mt_regfile_clr #(.NHARTS(3)) u_dut_b (
      .clk(clk), .n_reset(n_reset), .we(we), .wr_hart(wr_hart), .wr_addr(wr_addr),
      .wr_data(wr_data), .rd_hart(rd_hart), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .rd_data1(d1_b), .rd_data2(d2_b), .clr_req(clr_req), .clr_hart(clr_hart),
      .hart_busy(busy_b), .clr_done(done_b));

   mt_regfile_clr #(.BYPASS(0), .ZERO_R0(0)) u_dut_c (
      .clk(clk), .n_reset(n_reset), .we(we), .wr_hart(wr_hart), .wr_addr(wr_addr),
      .wr_data(wr_data), .rd_hart(rd_hart), .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
      .rd_data1(d1_c), .rd_data2(d2_c), .clr_req(clr_req), .clr_hart(clr_hart),
      .hart_busy(busy_c), .clr_done(done_c));

   typedef struct packed {
      logic [NC-1:0][31:0] r1;
      logic [NC-1:0][31:0] r2;
      logic [NC-1:0][3:0]  busy;
      logic [NC-1:0]       done;
   } exp_t;

   exp_t q[$];
   int vectors = 0;
   int miscompares = 0;

   // Reference model: bank contents plus a count of clear cycles still outstanding.
   logic [31:0] m [NC][4][NR];
   int  eng  [NC];
   bit  initc[NC];
   int  tgtc [NC];
   bit  donec[NC];

   function automatic logic [3:0] mbusy(int c);
      logic [3:0] v;
      if (eng[c] == 0)   v = 4'h0;
      else if (initc[c]) v = 4'((1 << nh_c[c]) - 1);
      else               v = 4'(1 << tgtc[c]);
      return v;
   endfunction

   function automatic bit wok(int c);
      logic [3:0] b;
      b = mbusy(c);
      return we && (int'(wr_hart) < nh_c[c]) && !b[wr_hart] &&
             !((z0_c[c] != 0) && (wr_addr == 5'd0));
   endfunction

   function automatic logic [31:0] rexp(int c, logic [4:0] a);
      logic [3:0] b;
      b = mbusy(c);
      if ((int'(rd_hart) >= nh_c[c]) || b[rd_hart]) return 32'h0;
      if ((z0_c[c] != 0) && (a == 5'd0)) return 32'h0;
      if ((byp_c[c] != 0) && wok(c) && (wr_hart == rd_hart) && (wr_addr == a)) return wr_data;
      return m[c][rd_hart][a];
   endfunction

   task automatic model_edge();
      for (int c = 0; c < NC; c++) begin
         if (!n_reset) begin
            for (int h = 0; h < 4; h++)
               for (int r = 0; r < NR; r++) m[c][h][r] = '0;
            eng[c] = NR; initc[c] = 1'b1; donec[c] = 1'b0;
         end else begin
            donec[c] = 1'b0;
            if (wok(c)) m[c][wr_hart][wr_addr] = wr_data;
            if (eng[c] > 0) begin
               eng[c]--;
               if (eng[c] == 0) donec[c] = 1'b1;
            end else if (clr_req && (int'(clr_hart) < nh_c[c])) begin
               tgtc[c] = int'(clr_hart); eng[c] = NR; initc[c] = 1'b0;
               for (int r = 0; r < NR; r++) m[c][clr_hart][r] = '0;
            end
         end
      end
   endtask

   task automatic step();
      exp_t e;
      for (int c = 0; c < NC; c++) begin
         e.r1[c]   = rexp(c, rd_addr1);
         e.r2[c]   = rexp(c, rd_addr2);
         e.busy[c] = mbusy(c);
         e.done[c] = donec[c];
      end
      q.push_back(e);
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic applyStimulus(input bit w, input int wh, input int wa, input logic [31:0] wd,
                                input int rh, input int ra1, input int ra2,
                                input bit cr, input int ch);
      we = w; wr_hart = 2'(wh); wr_addr = 5'(wa); wr_data = wd;
      rd_hart = 2'(rh); rd_addr1 = 5'(ra1); rd_addr2 = 5'(ra2);
      clr_req = cr; clr_hart = 2'(ch);
      step();
   endtask

   task automatic checkOutput(input string name, input int c, input logic [31:0] act,
                              input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s cfg%0d @%0t: got %h expected %h", name, c, $time, act, exp);
      end
   endtask

   // Monitor: outputs are combinational, so every queued entry is due at the next falling edge.
   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         checkOutput("rd_data1", 0, d1_a, e.r1[0]);
         checkOutput("rd_data2", 0, d2_a, e.r2[0]);
         checkOutput("hart_busy", 0, {28'h0, busy_a}, {28'h0, e.busy[0]});
         checkOutput("clr_done", 0, {31'h0, done_a}, {31'h0, e.done[0]});
         checkOutput("rd_data1", 1, d1_b, e.r1[1]);
         checkOutput("rd_data2", 1, d2_b, e.r2[1]);
         checkOutput("hart_busy", 1, {29'h0, busy_b}, {28'h0, e.busy[1]});
         checkOutput("clr_done", 1, {31'h0, done_b}, {31'h0, e.done[1]});
         checkOutput("rd_data1", 2, d1_c, e.r1[2]);
         checkOutput("rd_data2", 2, d2_c, e.r2[2]);
         checkOutput("hart_busy", 2, {28'h0, busy_c}, {28'h0, e.busy[2]});
         checkOutput("clr_done", 2, {31'h0, done_c}, {31'h0, e.done[2]});
      end
   end

   initial begin
      for (int c = 0; c < NC; c++) begin
         eng[c] = 0; initc[c] = 1'b0; tgtc[c] = 0; donec[c] = 1'b0;
      end
      // First reset edge establishes a known state before any checking.
      n_reset = 1'b0;
      @(posedge clk);
      model_edge();
      #1;
      for (int i = 0; i < 2; i++) applyStimulus(1, i, 3, 32'h1111, i, 0, 3, 0, 0);
      n_reset = 1'b1;
      for (int i = 0; i < 34; i++)
         applyStimulus($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 31), $urandom,
                       $urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 31), 0, 0);
      for (int h = 0; h < 4; h++)
         for (int a = 0; a < NR; a += 2) applyStimulus(0, 0, 0, 0, h, a, a + 1, 0, 0);

      applyStimulus(1, 2, 5, 32'hDEADBEEF, 2, 5, 0, 0, 0);
      applyStimulus(1, 0, 5, 32'h12345678, 2, 5, 5, 0, 0);
      for (int h = 0; h < 4; h++) applyStimulus(0, 0, 0, 0, h, 5, 4, 0, 0);

      applyStimulus(1, 1, 7, 32'hA5A5A5A5, 1, 7, 6, 0, 0);
      applyStimulus(1, 1, 0, 32'hFFFF0000, 1, 0, 7, 0, 0);
      applyStimulus(0, 0, 0, 0, 1, 0, 7, 0, 0);

      for (int r = 1; r < NR; r++) applyStimulus(1, 3, r, $urandom, 3, r, r - 1, 0, 0);
      applyStimulus(1, 1, 4, 32'h55, 1, 4, 0, 0, 0);
      // Accepted clear with a same-cycle write to the target: the write lands, then gets zeroed.
      applyStimulus(1, 3, 9, 32'hCAFEF00D, 3, 9, 1, 1, 3);
      for (int i = 0; i < 34; i++) begin
         if (i % 2 == 0) applyStimulus(1, 3, $urandom_range(1, 31), $urandom, 3, i % 32, 9, i == 15, 0);
         else            applyStimulus(1, 1, $urandom_range(5, 31), $urandom, 1, 4, $urandom_range(5, 31),
                                       i == 15, 0);
      end
      for (int i = 0; i < 36; i++) applyStimulus(0, 0, 0, 0, 3, i % 32, (i + 16) % 32, 0, 0);
      applyStimulus(0, 0, 0, 0, 1, 4, 0, 0, 0);

      applyStimulus(0, 0, 0, 0, 2, 0, 0, 1, 2);
      for (int i = 0; i < 10; i++) applyStimulus(1, 0, i + 1, $urandom, 2, i, 5, 0, 0);
      n_reset = 1'b0;
      applyStimulus(0, 0, 0, 0, 0, 5, 0, 0, 0);
      n_reset = 1'b1;
      for (int i = 0; i < 34; i++) applyStimulus(1, i % 4, 3, $urandom, i % 4, 3, 5, 1, 1);

      applyStimulus(1, 3, 8, 32'h0BADCAFE, 3, 8, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 3, 8, 0, 1, 3);
      applyStimulus(0, 0, 0, 0, 3, 8, 0, 0, 0);

      for (int i = 0; i < 600; i++) begin
         n_reset = ($urandom_range(0, 299) != 0);
         applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 3), $urandom_range(0, 31), $urandom,
                       $urandom_range(0, 3), $urandom_range(0, 31), $urandom_range(0, 31),
                       $urandom_range(0, 19) == 0, $urandom_range(0, 3));
      end
      n_reset = 1'b1;

      repeat (3) @(negedge clk);
      if (q.size() != 0) begin
         miscompares++;
         $display("[TB] FAIL scoreboard_drain: got %0d entries left expected 0", q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/mt_regfile_clr.md
Name: mt_regfile_clr

Overview:
- Parametrised multithreaded integer register file with one independent register bank per hardware thread (hart).
- Two combinational read ports and one write port; optional write-to-read bypass; optional hardwired-zero r0.
- Adds a sequential clear engine: zeroes all banks after reset, and zeroes a single hart's bank on request (thread restart or flush).
- Sits between ID (reads) and WB (writes) of the barrel-threaded pipeline; the hart scheduler consumes hart_busy.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, registers per hart; power of 2, ≥ 2.
- NHARTS, 4, number of harts; ≥ 1, not necessarily a power of 2.
- BYPASS, 1, when 1 a same-cycle write is forwarded to matching reads.
- ZERO_R0, 1, when 1 register 0 of every hart reads as zero and writes to it are discarded.
- Derived: AW = $clog2(NREGS); HW = max(1, $clog2(NHARTS)).

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- n_reset, input, 1, synchronous active-low reset.
- we, input, 1, write enable from WB.
- wr_hart, input, HW, hart of the write.
- wr_addr, input, AW, destination register.
- wr_data, input, XLEN, write data.
- rd_hart, input, HW, hart for both reads (ID stage).
- rd_addr1, input, AW, read port 1 address.
- rd_addr2, input, AW, read port 2 address.
- rd_data1, output, XLEN, read port 1 data (combinational).
- rd_data2, output, XLEN, read port 2 data (combinational).
- clr_req, input, 1, request to zero the bank of clr_hart.
- clr_hart, input, HW, target hart of a clear.
- hart_busy, output, NHARTS, bit h = 1 while bank h is being cleared.
- clr_done, output, 1, one-cycle pulse when a clear or init sequence completes.

Behaviour:
- Storage: NHARTS × NREGS × XLEN array. The array is not reset directly; it is zeroed by the INIT sequence.
- Reset: while n_reset = 0 at a clock edge, the next state is INIT, cnt = 0, hart_busy = all ones, clr_done = 0.
- Reset asserted mid-INIT or mid-CLR aborts the sequence and INIT restarts from cnt = 0.
- FSM states: INIT, IDLE, CLR. cnt is an AW-bit counter.
- INIT:
  - Each cycle, writes zero to register cnt of every hart; cnt increments.
  - When cnt = NREGS-1, that cycle's write still occurs; next state is IDLE with hart_busy = 0 and clr_done = 1 for one cycle.
  - Total duration: NREGS cycles after reset release.
- IDLE:
  - clr_req = 1 with clr_hart < NHARTS: latch clr_hart into tgt, set hart_busy[tgt] next cycle, cnt = 0, go to CLR.
  - clr_req with clr_hart ≥ NHARTS is ignored.
- CLR:
  - Each cycle, writes zero to register cnt of hart tgt.
  - At cnt = NREGS-1: go to IDLE, clear hart_busy[tgt], pulse clr_done.
  - Duration: NREGS cycles.
  - clr_req in INIT or CLR is ignored, not queued; the requester must hold it or re-issue it after clr_done.
- Writes:
  - Performed at the edge when we = 1 and all of the following hold: wr_hart < NHARTS; hart_busy[wr_hart] = 0; not (ZERO_R0 and wr_addr = 0).
  - Writes to a busy hart are dropped silently.
  - Writes to non-busy harts proceed during CLR in parallel with the clear engine.
- Reads (each port independently, in priority order):
  1. rd_hart ≥ NHARTS, or hart_busy[rd_hart] = 1 → 0.
  2. ZERO_R0 and addr = 0 → 0.
  3. BYPASS and we, and a qualifying write to the same hart and address → wr_data.
  4. Otherwise → the array value.
- Read latency: 0 cycles (combinational). Write-to-read latency: 0 cycles with BYPASS = 1, otherwise 1 cycle.
- Simultaneous clr_req (accepted) and a write to the same hart in the same cycle: the write is performed (the hart is not yet busy), then zeroed by the clear.
- clr_done is high only on the single cycle after the last clear write.

Test Plan:
- Reset and INIT: hold n_reset = 0 for 3 cycles, then release → hart_busy = 4'b1111 for exactly 32 cycles, then 4'b0000 with a single clr_done pulse; all 4×32 reads return 0.
- Per-hart write and isolation: write 0xDEADBEEF to hart 2 r5, and 0x12345678 to hart 0 r5 → hart 2 r5 = 0xDEADBEEF, hart 0 r5 = 0x12345678, harts 1 and 3 r5 = 0.
- Bypass and r0 (BYPASS = 1): in the same cycle, write 0xA5A5A5A5 to hart 1 r7 with rd_hart = 1, rd_addr1 = 7 → rd_data1 = 0xA5A5A5A5. Write to hart 1 r0 → r0 reads 0.
- Hart clear: preload hart 3 r1..r31 and hart 1 r4 = 0x55; pulse clr_req with clr_hart = 3 → hart_busy = 4'b1000 for 32 cycles; hart 3 writes are dropped and its reads return 0; hart 1 writes and reads unaffected; clr_done pulses; afterwards all hart 3 regs = 0 and hart 1 r4 = 0x55.
- Ignored request and mid-clear reset: clr_req for hart 0 issued during the hart 3 CLR → no effect. Assert n_reset at cnt = 10 → INIT restarts, hart_busy = all ones for 32 cycles.
- NHARTS = 3 configuration: write to hart 3 is ignored; read with rd_hart = 3 returns 0; clr_req with clr_hart = 3 → no state change.
